bcd_down_timer: RTL and testbench

Cascadable multi-digit BCD down-counter and interval timer. It mirrors the decade up-counter: it counts decimal digits downward with borrow instead of upward with carry. Software or control logic loads a BCD value, the block decrements once per enabled cycle, and it flags expiry with a one-cycle pulse. An optional auto-reload mode gives periodic ticks. It sits beside the decade counters in the counter/timer group and feeds event logic and display paths.

---
 rtl/counter_pkg.sv | 18 +
 rtl/bcd_digit_down.sv | 27 ++
 rtl/bcd_down_timer.sv | 115 +++++++++++
 tb/tb_bcd_down_timer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer group: BCD digit limits,
// the down-timer state type and a BCD nibble validity helper.
package counter_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A nibble is a legal BCD digit when it does not exceed 9.
  function automatic logic bcd_valid(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a borrow-rippling down-counter. Purely combinational:
// with a borrow in, a non-zero digit decrements and absorbs the borrow,
// while a zero digit wraps to 9 and passes the borrow on.
module bcd_digit_down
  import counter_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  // Next-digit and borrow decode for a single decade.
  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == BCD_MIN) begin
        next_digit = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Cascadable NDIG-digit BCD down-counter / interval timer with load
// validation, expiry pulse and optional auto-reload.
// Interface timing: no handshake; every input is level-sampled at each
// rising clock edge and takes effect on count/done/err one clock later.
module bcd_down_timer
  import counter_pkg::*;
#(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              en,
  input  logic              auto_reload,
  output logic [4*NDIG-1:0] count,
  output logic              zero,
  output logic              done,
  output logic              err
);

  localparam int W = 4 * NDIG;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    reload_q, reload_d;
  logic            done_d, err_d;
  logic            load_ok;
  logic [W-1:0]    dec_val;
  logic [NDIG:0]   borrow;

  // Digit 0 always receives the borrow; a borrow out of the top digit
  // means the count was already zero.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit_down u_digit (
      .digit      (count_q[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .next_digit (dec_val[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  // Load value is accepted only when every nibble is a legal BCD digit.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!bcd_valid(load_val[4*i +: 4])) load_ok = 1'b0;
    end
  end

  // Next-state, next-count and pulse decode: load beats counting.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (load) begin
      if (!load_ok) begin
        err_d = 1'b1;
      end else begin
        count_d  = load_val;
        reload_d = load_val;
        state_d  = (load_val != '0) ? RUN : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (en) begin
            if (borrow[NDIG]) begin
              // Never step from zero; park in IDLE instead.
              state_d = IDLE;
            end else if (count_q == ONE) begin
              done_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end else begin
              count_d = dec_val;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, count, reload and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer (NDIG=2): directed scenarios
// followed by random stimulus, all checked each cycle against a
// decimal-integer reference model through an expected queue.
module tb_bcd_down_timer;

  localparam int NDIG = 2;
  localparam int W    = 4 * NDIG;
  localparam int EW   = W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [W-1:0]  load_val;
  logic          en;
  logic          auto_reload;
  logic [W-1:0]  count;
  logic          zero;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain decimal integers.
  int m_val    = 0;
  int m_reload = 0;
  bit m_run    = 0;
  bit m_done   = 0;
  bit m_err    = 0;

  logic [EW-1:0] exp_q[$];

  bcd_down_timer #(.NDIG(NDIG)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .zero        (zero),
    .done        (done),
    .err         (err)
  );

  // Clock generation
  always #5 clk = ~clk;

  function automatic int from_bcd(input logic [W-1:0] b);
    int v = 0;
    for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b = '0;
    int t = v;
    for (int i = 0; i < NDIG; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic bit is_bcd(input logic [W-1:0] b);
    for (int i = 0; i < NDIG; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, pushes the expected outputs.
  task automatic model_edge(input bit r, input bit l, input logic [W-1:0] v,
                            input bit e, input bit a);
    if (r) begin
      m_val = 0; m_reload = 0; m_run = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (l) begin
        if (!is_bcd(v)) begin
          m_err = 1;
        end else begin
          m_val    = from_bcd(v);
          m_reload = m_val;
          m_run    = (m_val != 0);
        end
      end else if (m_run && e) begin
        if (m_val == 1) begin
          m_done = 1;
          if (a) m_val = m_reload;
          else begin
            m_val = 0;
            m_run = 0;
          end
        end else begin
          m_val = m_val - 1;
        end
      end
    end
    exp_q.push_back({m_done, m_err, to_bcd(m_val)});
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs.
  task automatic cycle(input bit r, input bit l, input logic [W-1:0] v,
                       input bit e, input bit a);
    logic [EW-1:0] exp;
    rst = r; load = l; load_val = v; en = e; auto_reload = a;
    @(posedge clk);
    model_edge(r, l, v, e, a);
    #1;
    exp = exp_q.pop_front();
    check_val("count", 32'(count), 32'(exp[W-1:0]));
    check_val("zero",  32'(zero),  32'(exp[W-1:0] == '0));
    check_val("done",  32'(done),  32'(exp[EW-1]));
    check_val("err",   32'(err),   32'(exp[EW-2]));
  endtask

  initial begin
    int lat;
    logic [W-1:0] rv;
    bit ar_r;

    // Reset with a competing load request
    cycle(1, 1, 8'h45, 0, 0);
    cycle(1, 1, 8'h45, 0, 0);

    // Basic countdown from 12 with done latency measurement
    cycle(0, 1, 8'h12, 1, 0);
    lat = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, 8'h00, 1, 0);
      if (done && lat == 0) lat = i + 1;
    end
    check_val("done_latency", 32'(lat), 32'd12);

    // Borrow across digits, then pause
    cycle(0, 1, 8'h10, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0, 0);

    // Auto-reload period of 3
    cycle(0, 1, 8'h03, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 8'h00, 1, 1);

    // Invalid load while counting at 7
    cycle(0, 1, 8'h08, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 1, 8'h1A, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);

    // Load colliding with expiry
    cycle(0, 1, 8'h02, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 1, 8'h05, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);

    // Reset while running, then auto-reload with enable after reset
    cycle(0, 1, 8'h37, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 0, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1, 1);

    // Random stimulus
    ar_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) ar_r = ~ar_r;
      case ($urandom_range(0, 3))
        0:       rv = to_bcd($urandom_range(0, 5));
        1:       rv = to_bcd($urandom_range(0, 99));
        2:       rv = W'($urandom);
        default: rv = to_bcd($urandom_range(1, 20));
      endcase
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, rv,
            $urandom_range(0, 99) < 85, ar_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
